// File: rtl/qda_dac_pkg.sv
// Shared definitions for the DAC daisy-chain loader: state encoding,
// default parameter values and the bit-ordering helper.
package qda_dac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SCLK_LOW  = 3'd1,
      ST_SCLK_HIGH = 3'd2,
      ST_LATCH     = 3'd3,
      ST_FINISH    = 3'd4
   } dac_state_e;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_N_CH      = 4;
   localparam int DEF_CNT_W     = 16;
   localparam bit DEF_MSB_FIRST = 1'b0;

   // Position in the serial stream of bit b of channel ch. The highest channel
   // goes out first so that channel 0 ends up in the DAC nearest the loader.
   function automatic int stream_pos(input int ch, input int b, input int n_ch,
                                     input int data_w, input bit msb_first);
      return (n_ch - 1 - ch) * data_w + (msb_first ? (data_w - 1 - b) : b);
   endfunction

endpackage

// File: rtl/qda_period_timer.sv
// Phase timer: down-counter loaded with a period (0 treated as 1) that
// flags expiry in the last cycle of the phase.
module qda_period_timer
   import qda_dac_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] period,
   output logic             expire
);

   logic [CNT_W-1:0] count;

   // Load clamps zero to one; counting stops at zero so it never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= (period == '0) ? CNT_W'(1) : period;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/qda_dac_chain_loader.sv
// Serial loader for a chain of DACs: shifts one frame of N_CH words out on
// SIN/SCLK, then strobes PCLK to latch all channels in parallel.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for UPDATE; shadows captured on acceptance
// ST_SCLK_LOW  | SCLK low, SIN shows current bit (or 0 in the trailing phase)
// ST_SCLK_HIGH | SCLK high, SIN held; DAC samples on the rising edge
// ST_LATCH     | PCLK high, SCLK and SIN low
// ST_FINISH    | single cycle with DONE high, then back to idle
module qda_dac_chain_loader
   import qda_dac_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int N_CH      = DEF_N_CH,
   parameter int CNT_W     = DEF_CNT_W,
   parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CNT_W-1:0]       LOAD_PERIOD,
   input  logic [CNT_W-1:0]       LATCH_PERIOD,
   input  logic                   UPDATE,
   input  logic [N_CH*DATA_W-1:0] REG_DATA,
   output logic                   SIN,
   output logic                   SCLK,
   output logic                   PCLK,
   output logic                   BUSY,
   output logic                   DONE
);

   localparam int N_BITS = N_CH * DATA_W;
   localparam int IDX_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);

   dac_state_e        state;
   logic [N_BITS-1:0] stream_in;
   logic [N_BITS-1:0] stream_sh;
   logic [CNT_W-1:0]  load_sh;
   logic [CNT_W-1:0]  latch_sh;
   logic [IDX_W-1:0]  bit_idx;
   logic [IDX_W-1:0]  next_idx;
   logic              trail;
   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic              expire;

   // Reorder REG_DATA into transmit order so bit 0 of the stream goes first.
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      for (genvar b = 0; b < DATA_W; b++) begin : g_bit
         localparam int POS = stream_pos(c, b, N_CH, DATA_W, MSB_FIRST);
         assign stream_in[POS] = REG_DATA[c*DATA_W + b];
      end
   end

   assign next_idx = bit_idx + IDX_W'(1);

   // Reload the shared timer on every phase change with the next phase length.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = latch_sh;
      unique case (state)
         ST_IDLE: begin
            tmr_load = UPDATE;
            tmr_val  = LATCH_PERIOD;
         end
         ST_SCLK_LOW: begin
            tmr_load = expire;
            tmr_val  = trail ? latch_sh : load_sh;
         end
         ST_SCLK_HIGH: begin
            tmr_load = expire;
            tmr_val  = latch_sh;
         end
         default: ;
      endcase
   end

   qda_period_timer #(.CNT_W(CNT_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load),
      .period (tmr_val),
      .expire (expire)
   );

   // Frame sequencer; outputs are updated together with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         stream_sh <= '0;
         load_sh   <= '0;
         latch_sh  <= '0;
         bit_idx   <= '0;
         trail     <= 1'b0;
         SIN       <= 1'b0;
         SCLK      <= 1'b0;
         PCLK      <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         DONE <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (UPDATE) begin
                  stream_sh <= stream_in;
                  load_sh   <= LOAD_PERIOD;
                  latch_sh  <= LATCH_PERIOD;
                  bit_idx   <= '0;
                  trail     <= 1'b0;
                  SIN       <= stream_in[0];
                  SCLK      <= 1'b0;
                  BUSY      <= 1'b1;
                  state     <= ST_SCLK_LOW;
               end
            end
            ST_SCLK_LOW: begin
               if (expire) begin
                  if (trail) begin
                     PCLK  <= 1'b1;
                     state <= ST_LATCH;
                  end else begin
                     SCLK  <= 1'b1;
                     state <= ST_SCLK_HIGH;
                  end
               end
            end
            ST_SCLK_HIGH: begin
               if (expire) begin
                  SCLK  <= 1'b0;
                  state <= ST_SCLK_LOW;
                  if (bit_idx == LAST_IDX) begin
                     trail <= 1'b1;
                     SIN   <= 1'b0;
                  end else begin
                     bit_idx <= next_idx;
                     SIN     <= stream_sh[next_idx];
                  end
               end
            end
            ST_LATCH: begin
               if (expire) begin
                  PCLK  <= 1'b0;
                  DONE  <= 1'b1;
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               BUSY    <= 1'b0;
               bit_idx <= '0;
               trail   <= 1'b0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qda_dac_chain_loader.sv
// Directed bench: two loaders (LSB-first and MSB-first) driven from the same
// stimulus, 2 channels of 16 bits each.
module tb_qda_dac_chain_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] load_p = 16'd3;
   logic [15:0] latch_p = 16'd2;
   logic        update = 1'b0;
   logic [31:0] reg_data = 32'h1234_ABCD;

   logic sin0, sclk0, pclk0, busy0, done0;
   logic sin1, sclk1, pclk1, busy1, done1;
   logic [1:0] sin_v, sclk_v, pclk_v, busy_v, done_v;

   int checks = 0;
   int errors = 0;

   int          r_busy[2], r_sclk[2], r_pclk[2], r_done[2], r_gap[2], r_bad[2];
   logic [31:0] r_cap[2];

   always #5 clk = ~clk;

   qda_dac_chain_loader #(.DATA_W(16), .N_CH(2), .CNT_W(16), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .LOAD_PERIOD(load_p), .LATCH_PERIOD(latch_p),
      .UPDATE(update), .REG_DATA(reg_data),
      .SIN(sin0), .SCLK(sclk0), .PCLK(pclk0), .BUSY(busy0), .DONE(done0)
   );

   qda_dac_chain_loader #(.DATA_W(16), .N_CH(2), .CNT_W(16), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .LOAD_PERIOD(load_p), .LATCH_PERIOD(latch_p),
      .UPDATE(update), .REG_DATA(reg_data),
      .SIN(sin1), .SCLK(sclk1), .PCLK(pclk1), .BUSY(busy1), .DONE(done1)
   );

   assign sin_v  = {sin1, sin0};
   assign sclk_v = {sclk1, sclk0};
   assign pclk_v = {pclk1, pclk0};
   assign busy_v = {busy1, busy0};
   assign done_v = {done1, done0};

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] rev16(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[15-i];
      return r;
   endfunction

   // Captured stream bit i sits at position i; channel 1 (0x1234) goes out first.
   function automatic logic [31:0] exp_cap(input int d, input logic [31:0] data);
      if (d == 0) return {data[15:0], data[31:16]};
      return {rev16(data[15:0]), rev16(data[31:16])};
   endfunction

   // Pulse UPDATE for one cycle and record one frame on both loaders.
   // At cycle disturb_at the inputs are scrambled and UPDATE pulsed again.
   task automatic run_frame(input int disturb_at);
      int   last_fall[2];
      logic prev_sclk[2];
      logic prev_pclk[2];
      for (int d = 0; d < 2; d++) begin
         r_busy[d] = 0; r_sclk[d] = 0; r_pclk[d] = 0; r_done[d] = 0;
         r_gap[d] = -1; r_bad[d] = 0; r_cap[d] = '0;
         last_fall[d] = 0; prev_sclk[d] = 1'b0; prev_pclk[d] = 1'b0;
      end
      @(negedge clk) update = 1'b1;
      @(negedge clk) update = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int d = 0; d < 2; d++) begin
            if (busy_v[d]) r_busy[d]++;
            if (sclk_v[d] && !prev_sclk[d]) begin
               if (r_sclk[d] < 32) r_cap[d][r_sclk[d]] = sin_v[d];
               r_sclk[d]++;
            end
            if (!sclk_v[d] && prev_sclk[d]) last_fall[d] = cyc;
            if (pclk_v[d] && !prev_pclk[d]) r_gap[d] = cyc - last_fall[d];
            if (pclk_v[d]) begin
               r_pclk[d]++;
               if (sin_v[d] || sclk_v[d]) r_bad[d]++;
            end
            if (done_v[d]) r_done[d]++;
            prev_sclk[d] = sclk_v[d];
            prev_pclk[d] = pclk_v[d];
         end
         if (cyc == disturb_at) begin
            update   = 1'b1;
            reg_data = 32'h5555_0F0F;
            load_p   = 16'd7;
            latch_p  = 16'd9;
         end else if (cyc == disturb_at + 1) begin
            update = 1'b0;
         end
         if (busy_v == 2'b00) break;
         @(negedge clk);
      end
   endtask

   task automatic check_frame(input string tag, input int exp_busy, input int per,
                              input logic [31:0] data);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_busy_cycles_d%0d", tag, d), r_busy[d], exp_busy);
         check($sformatf("%s_sclk_pulses_d%0d", tag, d), r_sclk[d], 32);
         check($sformatf("%s_stream_d%0d", tag, d), r_cap[d], exp_cap(d, data));
         check($sformatf("%s_pclk_width_d%0d", tag, d), r_pclk[d], per);
         check($sformatf("%s_pclk_gap_d%0d", tag, d), r_gap[d], per);
         check($sformatf("%s_latch_quiet_d%0d", tag, d), r_bad[d], 0);
         check($sformatf("%s_done_count_d%0d", tag, d), r_done[d], 1);
      end
   endtask

   initial begin : stim
      int pclk_seen, done_seen, frames, dones, busy_run, idle_run;
      logic prev_busy;

      // Reset with UPDATE also high: reset must win.
      update = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", {sin_v, sclk_v, pclk_v, busy_v, done_v}, 0);
      update = 1'b0;
      rst    = 1'b0;
      @(negedge clk);
      check("idle_after_reset", {sin_v, sclk_v, pclk_v, busy_v, done_v}, 0);

      // Basic frame, LATCH=2 LOAD=3: 1 + 32*5 + 2 + 2 = 165 busy cycles.
      run_frame(-10);
      check_frame("basic", 165, 2, 32'h1234_ABCD);

      // Zero periods behave as one: 1 + 32*2 + 1 + 1 = 67.
      load_p  = 16'd0;
      latch_p = 16'd0;
      run_frame(-10);
      check_frame("zero_per", 67, 1, 32'h1234_ABCD);

      // Mid-frame UPDATE with new data and periods is ignored.
      load_p  = 16'd3;
      latch_p = 16'd2;
      run_frame(40);
      check_frame("midframe", 165, 2, 32'h1234_ABCD);
      repeat (5) @(negedge clk);
      check("no_second_frame", busy_v, 2'b00);
      reg_data = 32'h1234_ABCD;
      load_p   = 16'd3;
      latch_p  = 16'd2;

      // Reset during bit 10 (its low phase starts at cycle 50).
      pclk_seen = 0;
      done_seen = 0;
      @(negedge clk) update = 1'b1;
      @(negedge clk) update = 1'b0;
      for (int cyc = 0; cyc < 52; cyc++) begin
         if (pclk_v != 0) pclk_seen++;
         if (done_v != 0) done_seen++;
         @(negedge clk);
      end
      check("busy_before_abort", busy_v, 2'b11);
      rst = 1'b1;
      @(negedge clk);
      check("abort_outputs", {sin_v, sclk_v, pclk_v, busy_v, done_v}, 0);
      rst = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         if (pclk_v != 0) pclk_seen++;
         if (done_v != 0) done_seen++;
         @(negedge clk);
      end
      check("abort_no_pclk", pclk_seen, 0);
      check("abort_no_done", done_seen, 0);
      check("abort_stays_idle", busy_v, 2'b00);
      run_frame(-10);
      check_frame("after_abort", 165, 2, 32'h1234_ABCD);

      // UPDATE held high: 67-cycle frames separated by one idle cycle.
      load_p    = 16'd0;
      latch_p   = 16'd0;
      frames    = 0;
      dones     = 0;
      busy_run  = 0;
      idle_run  = 0;
      prev_busy = 1'b0;
      @(negedge clk) update = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 450; s++) begin
         if (done0) dones++;
         if (busy0) begin
            if (!prev_busy && frames > 0)
               check($sformatf("held_idle_gap_%0d", frames), idle_run, 1);
            busy_run++;
            idle_run = 0;
         end else begin
            if (prev_busy) begin
               frames++;
               check($sformatf("held_frame_len_%0d", frames), busy_run, 67);
            end
            busy_run = 0;
            idle_run++;
         end
         check($sformatf("held_lockstep_%0d", s), busy1, busy0);
         prev_busy = busy0;
         if (s == 250) update = 1'b0;
         if (s > 250 && busy_v == 2'b00) break;
         @(negedge clk);
      end
      check("held_frames", frames, 4);
      check("held_dones", dones, 4);
      repeat (5) @(negedge clk);
      check("held_final_idle", busy_v, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
